// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for a two-source register file (ALU = A, load unit = B).
// Round-robin grant between the two requesters, a registered one-hot write
// port, and a pending-write scoreboard with a combinational hazard query.
module regfile_wb_arbiter #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [4:0]      a_rd,
   input  logic [XLEN-1:0] a_data,
   input  logic            b_valid,
   output logic            b_ready,
   input  logic [4:0]      b_rd,
   input  logic [XLEN-1:0] b_data,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rd,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   output logic [31:0]     wen,
   output logic [4:0]      wsel,
   output logic [XLEN-1:0] wdata,
   output logic [31:0]     busy,
   output logic            hazard
);

   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_e;

   prio_e            prio_q, prio_d;
   logic [31:0]      wen_q, wen_d;
   logic [4:0]       wsel_q, wsel_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;
   logic [31:0]      busy_q, busy_d;

   logic             xfer;
   logic [4:0]       g_rd;
   logic [XLEN-1:0]  g_data;

   // Grants: the prioritised requester wins a conflict; nothing granted in reset.
   always_comb begin
      a_ready = rst_n && a_valid && (!b_valid || (prio_q == PRIO_A));
      b_ready = rst_n && b_valid && (!a_valid || (prio_q == PRIO_B));
   end

   // Next-state: priority flip, registered write port and scoreboard update.
   always_comb begin
      prio_d  = prio_q;
      wen_d   = '0;
      wsel_d  = wsel_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      xfer    = a_ready || b_ready;
      g_rd    = a_ready ? a_rd   : b_rd;
      g_data  = a_ready ? a_data : b_data;

      if (xfer) begin
         prio_d  = a_ready ? PRIO_B : PRIO_A;
         wsel_d  = g_rd;
         wdata_d = g_data;
         if (g_rd != 5'd0) begin
            wen_d[g_rd] = 1'b1;
         end
         busy_d[g_rd] = 1'b0;
      end

      // Applied after the clear so a same-index issue keeps the bit set.
      if (issue_valid && (issue_rd != 5'd0)) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_q  <= PRIO_A;
         wen_q   <= '0;
         wsel_q  <= '0;
         wdata_q <= '0;
         busy_q  <= '0;
      end else begin
         prio_q  <= prio_d;
         wen_q   <= wen_d;
         wsel_q  <= wsel_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
      end
   end

   assign wen    = wen_q;
   assign wsel   = wsel_q;
   assign wdata  = wdata_q;
   assign busy   = busy_q;
   assign hazard = busy_q[rs1] || busy_q[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: the driver applies one cycle of
// stimulus, updates a behavioural model, and queues the expected outputs;
// two monitors pop and compare the combinational and registered outputs.
module tb_regfile_wb_arbiter;
   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            a_valid, b_valid, a_ready, b_ready;
   logic [4:0]      a_rd, b_rd, issue_rd, rs1, rs2, wsel;
   logic [XLEN-1:0] a_data, b_data, wdata;
   logic            issue_valid, hazard;
   logic [31:0]     wen, busy;

   regfile_wb_arbiter #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .rs1(rs1), .rs2(rs2),
      .wen(wen), .wsel(wsel), .wdata(wdata), .busy(busy), .hazard(hazard)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ar;
      logic br;
      logic hz;
   } comb_t;

   typedef struct {
      logic [31:0]     wen;
      logic [4:0]      wsel;
      logic [XLEN-1:0] wdata;
      logic [31:0]     busy;
   } reg_t;

   comb_t q_comb[$];
   reg_t  q_reg[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   bit              pend[32];
   bit              b_turn;
   logic [4:0]      m_wsel;
   logic [XLEN-1:0] m_wdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] pend_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = pend[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) pend[i] = 1'b0;
      b_turn  = 1'b0;
      m_wsel  = '0;
      m_wdata = '0;
   endtask

   // One stimulus cycle: drive at the falling edge, predict and enqueue.
   task automatic cyc(input logic rst, input logic av, input logic [4:0] ard,
                      input logic [XLEN-1:0] ad, input logic bv, input logic [4:0] brd,
                      input logic [XLEN-1:0] bd, input logic iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2);
      comb_t c;
      reg_t  r;
      bit    ga, gb;
      logic [4:0] rd;
      @(negedge clk);
      rst_n = rst; a_valid = av; a_rd = ard; a_data = ad;
      b_valid = bv; b_rd = brd; b_data = bd;
      issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;

      c.hz = pend[r1] | pend[r2];
      ga = 0; gb = 0;
      if (rst) begin
         if (av && (!bv || !b_turn)) ga = 1;
         else if (bv) gb = 1;
      end
      c.ar = ga; c.br = gb;
      q_comb.push_back(c);

      r.wen = '0;
      if (!rst) begin
         model_reset();
      end else begin
         if (ga || gb) begin
            rd      = ga ? ard : brd;
            m_wsel  = rd;
            m_wdata = ga ? ad : bd;
            if (rd != 0) r.wen = 32'd1 << rd;
            pend[rd] = 1'b0;
            b_turn   = ga;
         end
         if (iv && ird != 0) pend[ird] = 1'b1;
      end
      r.wsel  = m_wsel;
      r.wdata = m_wdata;
      r.busy  = pend_vec();
      q_reg.push_back(r);
   endtask

   task automatic idle(input logic [4:0] r1);
      cyc(1, 0, 0, '0, 0, 0, '0, 0, 0, r1, 0);
   endtask

   // Monitor for combinational outputs, sampled mid low phase.
   always begin
      comb_t c;
      @(negedge clk);
      #2;
      if (q_comb.size() > 0) begin
         c = q_comb.pop_front();
         chk("a_ready", a_ready, c.ar);
         chk("b_ready", b_ready, c.br);
         chk("hazard", hazard, c.hz);
         if (a_ready && b_ready) chk("ready_exclusive", 1'b1, 1'b0);
      end
   end

   // Monitor for registered outputs, sampled just after the rising edge.
   always begin
      reg_t r;
      @(posedge clk);
      #1;
      if (q_reg.size() > 0) begin
         r = q_reg.pop_front();
         chk("wen", wen, r.wen);
         chk("wsel", wsel, r.wsel);
         chk("wdata", wdata, r.wdata);
         chk("busy", busy, r.busy);
      end
   end

   initial begin
      rst_n = 0; a_valid = 0; b_valid = 0; a_rd = 0; b_rd = 0;
      a_data = '0; b_data = '0; issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
      model_reset();
      @(posedge clk);

      // Reset state
      cyc(0, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
      // Single A transfer to r5
      cyc(1, 1, 5, 32'h1234, 0, 0, '0, 0, 0, 0, 0);
      idle(0);
      idle(0);
      // Both valid from reset: A,B,A,B
      cyc(0, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
      cyc(1, 1, 1, 32'hA001, 1, 2, 32'hB002, 0, 0, 0, 0);
      cyc(1, 1, 3, 32'hA003, 1, 4, 32'hB004, 0, 0, 0, 0);
      cyc(1, 1, 5, 32'hA005, 1, 6, 32'hB006, 0, 0, 0, 0);
      cyc(1, 1, 7, 32'hA007, 1, 8, 32'hB008, 0, 0, 0, 0);
      // B write to r0
      cyc(1, 0, 0, '0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
      idle(0);
      // Scoreboard set / hazard / clear on r7
      cyc(1, 0, 0, '0, 0, 0, '0, 1, 7, 0, 0);
      idle(7);
      cyc(1, 1, 7, 32'h77, 0, 0, '0, 0, 0, 7, 0);
      idle(7);
      // Same-edge set and clear on r9
      cyc(1, 0, 0, '0, 0, 0, '0, 1, 9, 0, 9);
      cyc(1, 1, 9, 32'h99, 0, 0, '0, 1, 9, 0, 9);
      idle(9);
      // Mid-stream reset with busy = 0xF00
      for (int i = 8; i < 12; i++) cyc(1, 0, 0, '0, 0, 0, '0, 1, 5'(i), 8, 11);
      cyc(0, 1, 8, 32'h1, 1, 9, 32'h2, 1, 10, 8, 11);
      cyc(1, 1, 12, 32'h3, 1, 13, 32'h4, 0, 0, 8, 11);
      idle(0);

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 39) != 0),
             1'($urandom_range(0, 1)), 5'($urandom), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom), $urandom,
             ($urandom_range(0, 2) == 0), 5'($urandom),
             5'($urandom), 5'($urandom));
      end

      repeat (3) @(posedge clk);
      #2;
      chk("drain_comb", 64'(q_comb.size()), 64'd0);
      chk("drain_reg", 64'(q_reg.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
